// File: rtl/bool_sweep_ctrl.sv
// Exhaustive sweep sequencer for a small combinational boolean block: drives every
// input vector in ascending order, samples F after HOLD cycles and checks it against a latched table.
module bool_sweep_ctrl #(
    parameter int N_IN = 4,
    parameter int HOLD = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [(1<<N_IN)-1:0]   expected,
    input  logic                   f_in,
    output logic [N_IN-1:0]        vec_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(1<<N_IN)-1:0]   table_out,
    output logic [N_IN:0]          mismatch_cnt,
    output logic [N_IN-1:0]        first_fail
);
    localparam int NV = 1 << N_IN;
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [NV-1:0]   exp_l;
    logic            mis;

    assign mis = f_in ^ exp_l[vec_out];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            vec_out      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            table_out    <= '0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
            cnt          <= '0;
            exp_l        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    vec_out <= '0;
                    if (start) begin
                        state        <= RUN;
                        busy         <= 1'b1;
                        cnt          <= '0;
                        exp_l        <= expected;
                        table_out    <= '0;
                        mismatch_cnt <= '0;
                        first_fail   <= '0;
                        pass         <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        // partial results stay visible for debug
                        state   <= IDLE;
                        busy    <= 1'b0;
                        vec_out <= '0;
                        pass    <= 1'b0;
                    end else if (cnt != CW'(HOLD - 1)) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        cnt                <= '0;
                        table_out[vec_out] <= f_in;
                        if (mis) begin
                            mismatch_cnt <= mismatch_cnt + {{N_IN{1'b0}}, 1'b1};
                            if (mismatch_cnt == '0)
                                first_fail <= vec_out;
                        end
                        if (vec_out == {N_IN{1'b1}}) begin
                            // pass must include the compare happening on this edge
                            state   <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            vec_out <= '0;
                            pass    <= (mismatch_cnt == '0) && !mis;
                        end else begin
                            vec_out <= vec_out + N_IN'(1);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bool_sweep_ctrl.sv
// Bench for bool_sweep_ctrl: table of sweeps (spec cases plus random ones scored by a
// truth-table reference model), and hand sequences for restart-ignore, abort, reset, HOLD=1.
module tb_bool_sweep_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, start1 = 1'b0, abort = 1'b0, abort1 = 1'b0;
    logic [15:0] expected = '0;
    logic [15:0] model = '0;
    logic        use_a = 1'b0;
    logic        sel = 1'b0;

    logic [3:0]  vec0, vec1, ff0, ff1;
    logic        busy0, busy1, done0, done1, pass0, pass1;
    logic [15:0] tab0, tab1;
    logic [4:0]  mc0, mc1;
    logic        f0, f1;

    logic [3:0]  o_vec, o_first;
    logic        o_busy, o_done, o_pass;
    logic [15:0] o_tab;
    logic [4:0]  o_cnt;

    int total = 0, passed = 0;

    always #5 clk = ~clk;

    assign f0 = use_a ? vec0[3] : model[vec0];
    assign f1 = model[vec1];

    assign o_vec   = sel ? vec1  : vec0;
    assign o_busy  = sel ? busy1 : busy0;
    assign o_done  = sel ? done1 : done0;
    assign o_pass  = sel ? pass1 : pass0;
    assign o_tab   = sel ? tab1  : tab0;
    assign o_cnt   = sel ? mc1   : mc0;
    assign o_first = sel ? ff1   : ff0;

    bool_sweep_ctrl #(.N_IN(4), .HOLD(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .expected(expected),
        .f_in(f0), .vec_out(vec0), .busy(busy0), .done(done0), .pass(pass0),
        .table_out(tab0), .mismatch_cnt(mc0), .first_fail(ff0)
    );

    bool_sweep_ctrl #(.N_IN(4), .HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .expected(expected),
        .f_in(f1), .vec_out(vec1), .busy(busy1), .done(done1), .pass(pass1),
        .table_out(tab1), .mismatch_cnt(mc1), .first_fail(ff1)
    );

    typedef struct {
        logic        use_a;
        logic [15:0] model;
        logic [15:0] expv;
        logic [15:0] tab;
        int          cnt;
        int          first;
        logic        pass;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // Reference: the measured table is simply F's truth table; failures are its XOR with expected.
    function automatic vec_t ref_sweep(input logic ua, input logic [15:0] m, input logic [15:0] e);
        vec_t r;
        logic [15:0] tt, diff;
        for (int v = 0; v < 16; v++) tt[v] = ua ? v[3] : m[v];
        diff = tt ^ e;
        r.use_a = ua; r.model = m; r.expv = e; r.tab = tt;
        r.cnt = $countones(diff);
        r.first = 0;
        for (int v = 15; v >= 0; v--) if (diff[v]) r.first = v;
        r.pass = (r.cnt == 0);
        return r;
    endfunction

    task automatic do_start(input logic [15:0] e);
        @(negedge clk);
        expected = e;
        if (sel) start1 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start1 = 1'b0;
    endtask

    // Called #1 after the accepted start edge; poke_at >= 0 re-pulses start and flips expected mid-run.
    task automatic run_and_check(input string nm, input int hold, input vec_t x, input int poke_at);
        int busy_cyc = 0, done_at = -1, done_n = 0;
        bit vec_ok = 1'b1;
        for (int i = 0; i <= 16 * hold + 3; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            start = 1'b0;
            if (o_busy) busy_cyc++;
            if (o_done) begin done_n++; done_at = i; end
            if (i < 16 * hold) begin
                if (o_vec != 4'(i / hold)) vec_ok = 1'b0;
            end else if (o_vec != 4'd0) vec_ok = 1'b0;
            if (i == poke_at) begin
                start = 1'b1;
                expected = ~expected;
            end
        end
        chk({nm, " busy_cycles"}, busy_cyc, 16 * hold);
        chk({nm, " done_edge"}, done_at, 16 * hold);
        chk({nm, " done_pulses"}, done_n, 1);
        chk({nm, " vec_seq"}, vec_ok, 1);
        chk({nm, " table"}, o_tab, x.tab);
        chk({nm, " mcnt"}, o_cnt, x.cnt);
        chk({nm, " first"}, o_first, x.first);
        chk({nm, " pass"}, o_pass, x.pass);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " busy"}, busy0, 0);
        chk({nm, " done"}, done0, 0);
        chk({nm, " pass"}, pass0, 0);
        chk({nm, " vec"}, vec0, 0);
        chk({nm, " table"}, tab0, 0);
        chk({nm, " mcnt"}, mc0, 0);
        chk({nm, " first"}, ff0, 0);
    endtask

    initial begin
        int dn;
        vt.push_back('{1'b0, 16'hA5C3, 16'hA5C3,           16'hA5C3, 0,  0, 1'b1});
        vt.push_back('{1'b0, 16'hA5C3, 16'hA5C3 ^ 16'h0208, 16'hA5C3, 2,  3, 1'b0});
        vt.push_back('{1'b1, 16'h0000, 16'h0000,           16'hFF00, 8,  8, 1'b0});
        vt.push_back('{1'b0, 16'hFFFF, 16'h0000,           16'hFFFF, 16, 0, 1'b0});
        for (int r = 0; r < 4; r++) begin
            logic [15:0] m, e;
            m = 16'($urandom);
            e = (r == 0) ? m : (m ^ (16'($urandom) & 16'($urandom)));
            vt.push_back(ref_sweep(1'b0, m, e));
        end

        #12;
        chk_reset_vals("reset");
        @(negedge clk); rst = 1'b0;

        for (int t = 0; t < vt.size(); t++) begin
            model = vt[t].model; use_a = vt[t].use_a;
            do_start(vt[t].expv);
            run_and_check($sformatf("sweep%0d", t), 2, vt[t], -1);
        end

        // start re-pulsed with a different expected at vector 4: must be ignored
        model = 16'hA5C3; use_a = 1'b0;
        do_start(16'hA5C3);
        run_and_check("restart_ign", 2, vt[0], 8);

        // abort at vector 5
        do_start(16'hA5C3);
        repeat (10) @(posedge clk);
        #1;
        chk("abort pre_vec", vec0, 5);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort busy", busy0, 0);
        chk("abort vec", vec0, 0);
        chk("abort pass", pass0, 0);
        chk("abort partial_table", tab0, 16'h0003);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (done0) dn++;
            @(posedge clk); #1;
        end
        chk("abort no_done", dn, 0);
        do_start(16'hA5C3);
        run_and_check("after_abort", 2, vt[0], -1);

        // async reset at vector 9
        do_start(16'hA5C3 ^ 16'h0208);
        repeat (18) @(posedge clk);
        #1;
        chk("rst pre_vec", vec0, 9);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk); rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done0) dn++;
        end
        chk("midrst no_done", dn, 0);
        model = 16'h0000; use_a = 1'b1;
        do_start(16'h0000);
        run_and_check("after_rst", 2, vt[2], -1);

        // HOLD=1 instance
        sel = 1'b1; use_a = 1'b0; model = 16'hFFFF;
        do_start(16'hFFFF);
        run_and_check("hold1", 1, ref_sweep(1'b0, 16'hFFFF, 16'hFFFF), -1);
        model = 16'h3C5A;
        do_start(16'h3C5B);
        run_and_check("hold1_fail", 1, ref_sweep(1'b0, 16'h3C5A, 16'h3C5B), -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
